// File: rtl/vram_writer_if.sv
// Bus bundle for vram_writer: command FIFO head, display read port and SRAM pins.
interface vram_writer_if #(
  parameter int unsigned AWIDTH = 19,
  parameter int unsigned DWIDTH = 8
);
  // Command FIFO head and pop strobe
  logic              HasReadData;
  logic [AWIDTH-1:0] AddrIn;
  logic [DWIDTH-1:0] DataIn;
  logic              ReadOutClk;

  // Display read port
  logic              PixReq;
  logic [AWIDTH-1:0] PixAddr;
  logic [DWIDTH-1:0] PixData;
  logic              PixValid;

  // Asynchronous SRAM pins
  logic [AWIDTH-1:0] SramAddr;
  logic [DWIDTH-1:0] SramDout;
  logic              SramDoe;
  logic [DWIDTH-1:0] SramDin;
  logic              SramCeN;
  logic              SramOeN;
  logic              SramWeN;

  // Controller status
  logic              Busy;

  // The controller: owns the SRAM strobes, the pop strobe and the pixel result.
  modport master (
    input  HasReadData, AddrIn, DataIn, PixReq, PixAddr, SramDin,
    output ReadOutClk, PixData, PixValid, SramAddr, SramDout, SramDoe,
           SramCeN, SramOeN, SramWeN, Busy
  );

  // The surroundings: FIFO, display requester and SRAM device.
  modport slave (
    output HasReadData, AddrIn, DataIn, PixReq, PixAddr, SramDin,
    input  ReadOutClk, PixData, PixValid, SramAddr, SramDout, SramDoe,
           SramCeN, SramOeN, SramWeN, Busy
  );
endinterface

// File: rtl/vram_writer.sv
// Arbitrates display reads and FIFO-fed writes onto a single asynchronous SRAM.
// Reads take priority except that a pending write always follows a read, so
// neither side can starve. Every SRAM pin and handshake output is a flop.
module vram_writer #(
  parameter int unsigned WR_CYCLES = 2,
  parameter int unsigned AWIDTH    = 19,
  parameter int unsigned DWIDTH    = 8
) (
  input logic       Clk,
  input logic       ResetN,
  vram_writer_if.master bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_SETUP  = 3'd1,
    RD_SAMPLE = 3'd2,
    WR_SETUP  = 3'd3,
    WR_PULSE  = 3'd4,
    WR_HOLD   = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] pulse_cnt;
  logic             last_read;  // previous granted operation was a read
  logic             armed;      // low for the first edge after reset release
  logic             grant_rd;
  logic             grant_wr;

  // Grant decision in IDLE: read wins unless the last grant was a read.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (state == IDLE && armed && !bus.PixValid) begin
      if (bus.PixReq && bus.HasReadData) begin
        grant_wr = last_read;
        grant_rd = !last_read;
      end else begin
        grant_rd = bus.PixReq;
        grant_wr = bus.HasReadData;
      end
    end
  end

  // Sequencer: state, WE pulse counter and all registered outputs.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state          <= IDLE;
      pulse_cnt      <= '0;
      last_read      <= 1'b0;
      armed          <= 1'b0;
      bus.SramCeN    <= 1'b1;
      bus.SramOeN    <= 1'b1;
      bus.SramWeN    <= 1'b1;
      bus.SramDoe    <= 1'b0;
      bus.ReadOutClk <= 1'b0;
      bus.PixValid   <= 1'b0;
      bus.PixData    <= DWIDTH'(0);
      bus.SramAddr   <= AWIDTH'(0);
      bus.SramDout   <= DWIDTH'(0);
      bus.Busy       <= 1'b0;
    end else begin
      armed          <= 1'b1;
      bus.ReadOutClk <= 1'b0;
      bus.PixValid   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_rd) begin
            state        <= RD_SETUP;
            bus.SramAddr <= bus.PixAddr;
            bus.SramCeN  <= 1'b0;
            bus.SramOeN  <= 1'b0;
            bus.Busy     <= 1'b1;
            last_read    <= 1'b1;
          end else if (grant_wr) begin
            // The FIFO entry is captured here; the pop makes it ours alone.
            state          <= WR_SETUP;
            bus.SramAddr   <= bus.AddrIn;
            bus.SramDout   <= bus.DataIn;
            bus.SramDoe    <= 1'b1;
            bus.SramCeN    <= 1'b0;
            bus.ReadOutClk <= 1'b1;
            bus.Busy       <= 1'b1;
            last_read      <= 1'b0;
          end
        end
        RD_SETUP: begin
          state <= RD_SAMPLE;
        end
        RD_SAMPLE: begin
          state        <= IDLE;
          bus.PixData  <= bus.SramDin;
          bus.PixValid <= 1'b1;
          bus.SramCeN  <= 1'b1;
          bus.SramOeN  <= 1'b1;
          bus.Busy     <= 1'b0;
        end
        WR_SETUP: begin
          state       <= WR_PULSE;
          bus.SramWeN <= 1'b0;
          pulse_cnt   <= CNT_W'(WR_CYCLES - 1);
        end
        WR_PULSE: begin
          if (pulse_cnt == '0) begin
            state       <= WR_HOLD;
            bus.SramWeN <= 1'b1;
          end else begin
            pulse_cnt <= pulse_cnt - CNT_W'(1);
          end
        end
        WR_HOLD: begin
          state       <= IDLE;
          bus.SramDoe <= 1'b0;
          bus.SramCeN <= 1'b1;
          bus.Busy    <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          bus.SramCeN <= 1'b1;
          bus.SramOeN <= 1'b1;
          bus.SramWeN <= 1'b1;
          bus.SramDoe <= 1'b0;
          bus.Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_writer.sv
// Scoreboard bench for vram_writer: stimulus queues expected writes/reads,
// a negedge monitor pops and compares whenever the DUT pops the FIFO or
// returns pixel data, and checks strobe invariants every cycle.
`timescale 1ns/1ps
module tb_vram_writer;

  localparam int unsigned AW  = 19;
  localparam int unsigned DW  = 8;
  localparam int unsigned WRC = 2;

  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          lat_chk;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic Clk    = 1'b0;
  logic ResetN = 1'b0;

  vram_writer_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  vram_writer #(.WR_CYCLES(WRC), .AWIDTH(AW), .DWIDTH(DW)) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  exp_t exp_q[$];
  ent_t fifo_q[$];
  ent_t pix_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses = 0;
  bit burst_chk = 1'b0;

  // monitor / driver state (owned by the negedge block)
  int            req_cyc = 0;
  int            we_low = 0;
  int            oe_low = 0;
  int            busy_len = 0;
  int            last_roc = -1;
  bit            prev_roc = 1'b0;
  bit            prev_pv = 1'b0;
  bit            busy_was_wr = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_data = '0;
  logic [AW-1:0] rd_addr = '0;
  exp_t          mon_e;
  ent_t          dr_tmp;

  always @(posedge Clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ent_t t;
    exp_t e;
    t.addr = a; t.data = d;
    e.is_wr = 1'b1; e.addr = a; e.data = d; e.lat_chk = 1'b0;
    fifo_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input logic [AW-1:0] a, input logic [DW-1:0] din, input logic lat);
    ent_t t;
    exp_t e;
    t.addr = a; t.data = din;
    e.is_wr = 1'b0; e.addr = a; e.data = din; e.lat_chk = lat;
    pix_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.Busy || bus.PixValid) && n < budget) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    repeat (3) @(posedge Clk);
    #1;
  endtask

  // Monitor first, then the FIFO/requester model, in one block to avoid races.
  always @(negedge Clk) begin
    if (!ResetN) begin
      we_low   = 0;
      oe_low   = 0;
      busy_len = 0;
      prev_roc = 1'b0;
      prev_pv  = 1'b0;
      last_roc = -1;
    end else begin
      chk("oe_doe_exclusive", 32'(!bus.SramOeN && bus.SramDoe), 0);
      if (!burst_chk) last_roc = -1;

      if (bus.ReadOutClk) begin
        pulses++;
        busy_was_wr = 1'b1;
        chk("roc_single_cycle", 32'(prev_roc), 0);
        if (burst_chk && last_roc >= 0) chk("roc_spacing", cyc - last_roc, 5);
        last_roc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("order_is_write", 32'(mon_e.is_wr), 1);
          chk("wr_addr", 32'(bus.SramAddr), 32'(mon_e.addr));
          chk("wr_data", 32'(bus.SramDout), 32'(mon_e.data));
          chk("wr_setup_doe", 32'(bus.SramDoe), 1);
          cur_addr = mon_e.addr;
          cur_data = mon_e.data;
        end
      end

      if (!bus.SramWeN) begin
        we_low++;
        chk("we_context", 32'({bus.SramDoe, bus.SramCeN, bus.SramOeN, bus.ReadOutClk}), 32'h0000_000A);
        chk("we_within_pulse", 32'(we_low <= WRC), 1);
        chk("we_addr_hold", 32'(bus.SramAddr), 32'(cur_addr));
        chk("we_data_hold", 32'(bus.SramDout), 32'(cur_data));
      end else if (we_low != 0) begin
        chk("we_low_cycles", we_low, 2);
        we_low = 0;
      end

      if (!bus.SramOeN) begin
        if (oe_low == 0) begin
          rd_addr     = bus.SramAddr;
          busy_was_wr = 1'b0;
        end
        oe_low++;
        if (burst_chk) chk("no_oe_in_burst", 32'(bus.SramOeN), 1);
      end

      if (bus.PixValid) begin
        chk("pv_single_cycle", 32'(prev_pv), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_read", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("order_is_read", 32'(mon_e.is_wr), 0);
          chk("pix_data", 32'(bus.PixData), 32'(mon_e.data));
          chk("rd_addr", 32'(rd_addr), 32'(mon_e.addr));
          chk("oe_low_cycles", oe_low, 2);
          if (mon_e.lat_chk) chk("rd_latency", cyc - req_cyc, 3);
        end
        oe_low = 0;
      end

      if (bus.Busy) begin
        busy_len++;
      end else if (busy_len != 0) begin
        chk("busy_len", busy_len, busy_was_wr ? 4 : 2);
        busy_len = 0;
      end

      prev_roc = bus.ReadOutClk;
      prev_pv  = bus.PixValid;
    end

    // FIFO model: the entry under a ReadOutClk pulse is gone.
    if (bus.ReadOutClk && fifo_q.size() != 0) dr_tmp = fifo_q.pop_front();
    // Requester model: drop the serviced request when PixValid shows.
    if (bus.PixValid && pix_q.size() != 0) dr_tmp = pix_q.pop_front();

    bus.HasReadData = (fifo_q.size() != 0);
    if (fifo_q.size() != 0) begin
      bus.AddrIn = fifo_q[0].addr;
      bus.DataIn = fifo_q[0].data;
    end
    if (pix_q.size() != 0) begin
      if (!bus.PixReq || bus.PixValid) req_cyc = cyc;
      bus.PixReq  = 1'b1;
      bus.PixAddr = pix_q[0].addr;
      bus.SramDin = pix_q[0].data;
    end else begin
      bus.PixReq = 1'b0;
    end
  end

  // Directed stimulus.
  initial begin
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_cen",   32'(bus.SramCeN), 1);
    chk("rst_oen",   32'(bus.SramOeN), 1);
    chk("rst_wen",   32'(bus.SramWeN), 1);
    chk("rst_doe",   32'(bus.SramDoe), 0);
    chk("rst_roc",   32'(bus.ReadOutClk), 0);
    chk("rst_pv",    32'(bus.PixValid), 0);
    chk("rst_pdata", 32'(bus.PixData), 0);
    chk("rst_addr",  32'(bus.SramAddr), 0);
    chk("rst_dout",  32'(bus.SramDout), 0);
    chk("rst_busy",  32'(bus.Busy), 0);
    #2 ResetN = 1'b1;
    repeat (2) @(posedge Clk);
    #1;

    // single write
    push_wr(19'h12345, 8'hA5);
    drain("single_write", 100);

    // single read, latency 3
    push_rd(19'h00010, 8'h3C, 1'b1);
    drain("single_read", 100);

    // eight queued writes, 5-cycle spacing, no reads
    burst_chk = 1'b1;
    push_wr(19'h20000, 8'h10);
    push_wr(19'h20003, 8'h11);
    push_wr(19'h20006, 8'h12);
    push_wr(19'h20009, 8'h13);
    push_wr(19'h2000C, 8'h14);
    push_wr(19'h2000F, 8'h15);
    push_wr(19'h20012, 8'h16);
    push_wr(19'h20015, 8'h17);
    drain("burst8", 200);
    burst_chk = 1'b0;

    // contention: last op was a write, so read, write, read, write
    push_rd(19'h00100, 8'h11, 1'b0);
    push_wr(19'h30001, 8'h22);
    push_rd(19'h00200, 8'h33, 1'b0);
    push_wr(19'h30002, 8'h44);
    drain("contention", 200);

    // reset during WE pulse
    push_wr(19'h00777, 8'h5A);
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk);
      #1;
      if (!bus.SramWeN) break;
    end
    chk("reached_we_pulse", 32'(bus.SramWeN), 0);
    #1 ResetN = 1'b0;
    #1;
    chk("async_rst_wen", 32'(bus.SramWeN), 1);
    chk("async_rst_cen", 32'(bus.SramCeN), 1);
    chk("async_rst_doe", 32'(bus.SramDoe), 0);
    chk("async_rst_busy", 32'(bus.Busy), 0);
    repeat (2) @(posedge Clk);
    #1;
    // read request held across reset, serviced afterwards
    push_rd(19'h00ABC, 8'hC3, 1'b0);
    @(posedge Clk);
    #3 ResetN = 1'b1;
    @(posedge Clk);
    #1;
    chk("no_grant_release_edge", 32'(bus.Busy), 0);
    chk("idle_after_release", 32'(bus.SramCeN), 1);
    @(posedge Clk);
    #1;
    chk("grant_after_release", 32'(bus.Busy), 1);
    drain("post_reset_read", 100);

    chk("roc_pulse_total", pulses, 12);
    chk("fifo_empty", fifo_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if the run ever wedges.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vram_writer.md
VRAM_WRITER -- requirements
Module: vram_writer

Interface
Parameters:
REQ-001 SHALL have parameter WR_CYCLES, default 2, giving the number of cycles SramWeN is held low per write (legal range 1..15).
REQ-002 SHALL have parameter AWIDTH, default 19, giving the SRAM address width.
REQ-003 SHALL have parameter DWIDTH, default 8, giving the SRAM data width.
Ports:
REQ-004 SHALL have Clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have ResetN, input, 1: asynchronous active-low reset.
REQ-006 SHALL have HasReadData, input, 1: the command FIFO is non-empty.
REQ-007 SHALL have AddrIn, input, AWIDTH: write address at the command FIFO head.
REQ-008 SHALL have DataIn, input, DWIDTH: write data at the command FIFO head.
REQ-009 SHALL have ReadOutClk, output, 1: FIFO pop strobe; its rising edge pops one entry.
REQ-010 SHALL have PixReq, input, 1: display read request, a level held until PixValid.
REQ-011 SHALL have PixAddr, input, AWIDTH: display read address, stable while PixReq is high.
REQ-012 SHALL have PixData, output, DWIDTH: display read result.
REQ-013 SHALL have PixValid, output, 1: PixData is valid; one-cycle pulse.
REQ-014 SHALL have SramAddr, output, AWIDTH: SRAM address.
REQ-015 SHALL have SramDout, output, DWIDTH: SRAM write data.
REQ-016 SHALL have SramDoe, output, 1: tristate enable for SramDout.
REQ-017 SHALL have SramDin, input, DWIDTH: SRAM read data.
REQ-018 SHALL have SramCeN, SramOeN and SramWeN, outputs, 1 each: active-low SRAM strobes.
REQ-019 SHALL have Busy, output, 1: the FSM is not in IDLE.

Function
REQ-020 SHALL implement the FSM states IDLE, RD_SETUP, RD_SAMPLE, WR_SETUP, WR_PULSE and WR_HOLD.
REQ-021 SHALL, in IDLE with PixValid low, grant PixReq over HasReadData, except that a write SHALL be granted when both are pending and the previous granted operation was a read.
REQ-022 SHALL implement the read sequence: IDLE->RD_SETUP latches PixAddr to SramAddr; RD_SETUP and RD_SAMPLE drive SramOeN=0; SramDin is registered into PixData at the end of RD_SAMPLE; the FSM returns to IDLE with PixValid=1 for exactly that following cycle.
REQ-023 SHALL give read latency: PixReq sampled in cycle N -> PixValid=1 in cycle N+3.
REQ-024 SHALL NOT grant a new request in the IDLE cycle where PixValid=1; the requester drops PixReq in that cycle.
REQ-025 SHALL implement the write sequence: IDLE->WR_SETUP latches AddrIn and DataIn into internal registers; ReadOutClk=1 for exactly the WR_SETUP cycle (registered, glitch-free).
REQ-026 SHALL drive SramDout and SramDoe=1 from the latched data throughout WR_SETUP, WR_PULSE and WR_HOLD.
REQ-027 SHALL drive SramWeN=0 only in WR_PULSE, which SHALL last WR_CYCLES cycles counted by a 4-bit down-counter.
REQ-028 SHALL make one write occupy 2+WR_CYCLES cycles (4 at the default).
REQ-029 SHALL hold SramAddr constant through every WR_* state and through both RD_* states.
REQ-030 SHALL drive SramCeN=0 in every non-IDLE state and 1 in IDLE.
REQ-031 SHALL drive SramOeN=1 in all WR_* states.
REQ-032 SHALL hold SramDoe=0 in all RD_* states and in IDLE.
REQ-033 SHALL never have SramOeN=0 and SramDoe=1 in the same cycle.
REQ-034 SHALL ignore deassertion of HasReadData after WR_SETUP is entered, since the entry is already latched and popped.
REQ-035 SHALL ignore PixReq changes mid-read and SHALL ignore AddrIn/DataIn changes mid-write.
REQ-036 SHALL, on back-to-back FIFO entries with no PixReq, start the next WR_SETUP in the cycle after the IDLE that follows WR_HOLD (5-cycle period at the default).

Reset
REQ-037 SHALL, on ResetN=0 and immediately (asynchronously), force state=IDLE, SramCeN=1, SramOeN=1, SramWeN=1, SramDoe=0, ReadOutClk=0, PixValid=0, PixData=0, SramAddr=0, SramDout=0, Busy=0 and the last-operation flag to write.
REQ-038 SHALL discard an entry that was popped before a reset mid-write, with no re-pop; the FIFO is owned upstream.
REQ-039 SHALL leave an interrupted read with no PixValid; the requester's held PixReq is serviced after reset.
REQ-040 SHALL NOT grant any request in the cycle of the ResetN release edge.

Verification
REQ-041 SHALL cover: single write, AddrIn=19'h12345, DataIn=8'hA5 -> exactly one ReadOutClk pulse, SramWeN low 2 cycles with SramAddr=19'h12345 and SramDout=8'hA5, Busy for 4 cycles.
REQ-042 SHALL cover: read, PixReq with PixAddr=19'h00010 and SramDin=8'h3C -> SramOeN low 2 cycles, PixValid=1 with PixData=8'h3C 3 cycles after the request.
REQ-043 SHALL cover: PixReq and HasReadData both high continuously -> granted order read, write, read, write; no PixReq starves and no two consecutive writes occur.
REQ-044 SHALL cover: 8 queued entries with no PixReq -> 8 ReadOutClk pulses at a 5-cycle spacing, writes in FIFO order, and SramOeN never low.
REQ-045 SHALL cover: ResetN asserted during WR_PULSE -> SramWeN=1, SramCeN=1, SramDoe=0 within the same cycle, no further ReadOutClk pulse, and FSM in IDLE after release.
REQ-046 SHALL cover: assertion check every cycle -> never (SramOeN=0 and SramDoe=1), and never SramWeN=0 outside WR_PULSE.
